// File: rtl/column_feeder.sv
// column_feeder
//   Streaming 5-row line buffer placed directly upstream of DoGUnit. It takes
//   one pixel per accepted cycle in scan order (raster, or serpentine when
//   SERPENTINE=1) and keeps the previous four rows in four line memories
//   addressed by x. For every accepted pixel it emits one vertical 5-pixel
//   column, together with its coordinates and scan direction, one cycle later.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous reset, active low
//   pix_in        8-bit input pixel
//   pix_valid     pix_in is valid; a pixel is accepted only when this is high
//   sof           start of frame; sampled only together with pix_valid
//   data1..data5  column, row y-4 (data1) down to the current row y (data5)
//   Xout          column x coordinate
//   Yout          window centre row (y-2)
//   Directionout  0 = left-to-right row, 1 = right-to-left row
//   col_valid     column outputs are valid this cycle
//   frame_done    one-cycle pulse with the column of the last pixel of a frame
module column_feeder #(
  parameter int IMG_W      = 128,
  parameter int IMG_H      = 128,
  parameter int SERPENTINE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pix_in,
  input  logic       pix_valid,
  input  logic       sof,
  output logic [7:0] data1,
  output logic [7:0] data2,
  output logic [7:0] data3,
  output logic [7:0] data4,
  output logic [7:0] data5,
  output logic [7:0] Xout,
  output logic [7:0] Yout,
  output logic       Directionout,
  output logic       col_valid,
  output logic       frame_done
);

  localparam int         DATA_W = 8;
  localparam int         ADDR_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [7:0] X_LAST = 8'(IMG_W - 1);
  localparam logic [7:0] Y_LAST = 8'(IMG_H - 1);

  // Scan position of the next pixel and the rotating line-memory base.
  logic [7:0] xCnt;
  logic [7:0] yCnt;
  logic       dirCnt;
  logic [1:0] rb;

  // Four line memories; not reset.
  logic [DATA_W-1:0] lineMem [4][IMG_W];

  // ---- stage p0: position of the pixel presented this cycle ----
  logic [7:0]        x_p0;
  logic [7:0]        y_p0;
  logic              dir_p0;
  logic [1:0]        rb_p0;
  logic              rowEnd_p0;
  logic              lastRow_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [1:0]        rowM1_p0;
  logic [1:0]        rowM2_p0;
  logic [1:0]        rowM3_p0;
  logic [1:0]        rowM4_p0;
  logic              emit_p0;

  logic [7:0] xNext;
  logic [7:0] yNext;
  logic       dirNext;
  logic [1:0] rbNext;

  // sof forces the pixel to (0,0), whatever the counters hold.
  always_comb begin
    if (sof) begin
      x_p0   = '0;
      y_p0   = '0;
      dir_p0 = 1'b0;
      rb_p0  = '0;
    end else begin
      x_p0   = xCnt;
      y_p0   = yCnt;
      dir_p0 = dirCnt;
      rb_p0  = rb;
    end
  end

  assign rowEnd_p0  = dir_p0 ? (x_p0 == 8'd0) : (x_p0 == X_LAST);
  assign lastRow_p0 = (y_p0 == Y_LAST);
  assign addr_p0    = x_p0[ADDR_W-1:0];
  assign emit_p0    = pix_valid && (y_p0 >= 8'd4);

  // rb holds row y-1; the array after it in rotation order holds the oldest
  // row (y-4), which is the one overwritten by the incoming pixel. Advancing
  // rb at row end turns the row just written into the new y-1.
  assign rowM1_p0 = rb_p0;
  assign rowM2_p0 = rb_p0 + 2'd3;
  assign rowM3_p0 = rb_p0 + 2'd2;
  assign rowM4_p0 = rb_p0 + 2'd1;

  always_comb begin
    xNext   = x_p0;
    yNext   = y_p0;
    dirNext = dir_p0;
    rbNext  = rb_p0;
    if (rowEnd_p0) begin
      rbNext = rb_p0 + 2'd1;
      if (lastRow_p0) begin
        xNext   = '0;
        yNext   = '0;
        dirNext = 1'b0;
      end else begin
        yNext = y_p0 + 8'd1;
        // Serpentine keeps x at the edge; the next row walks back from it.
        if (SERPENTINE != 0) dirNext = ~dir_p0;
        else                 xNext   = '0;
      end
    end else if (dir_p0) begin
      xNext = x_p0 - 8'd1;
    end else begin
      xNext = x_p0 + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xCnt   <= '0;
      yCnt   <= '0;
      dirCnt <= 1'b0;
      rb     <= '0;
    end else if (pix_valid) begin
      xCnt   <= xNext;
      yCnt   <= yNext;
      dirCnt <= dirNext;
      rb     <= rbNext;
    end
  end

  // Reads below see the pre-write contents, so the oldest row is still
  // delivered on data1 in the same cycle it is replaced.
  always_ff @(posedge clk) begin
    if (pix_valid) lineMem[rowM4_p0][addr_p0] <= pix_in;
  end

  // ---- stage p1: registered column outputs ----
  logic [DATA_W-1:0] col1_p1;
  logic [DATA_W-1:0] col2_p1;
  logic [DATA_W-1:0] col3_p1;
  logic [DATA_W-1:0] col4_p1;
  logic [DATA_W-1:0] col5_p1;
  logic [7:0]        x_p1;
  logic [7:0]        y_p1;
  logic              dir_p1;
  logic              vld_p1;
  logic              done_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col1_p1 <= '0;
      col2_p1 <= '0;
      col3_p1 <= '0;
      col4_p1 <= '0;
      col5_p1 <= '0;
      x_p1    <= '0;
      y_p1    <= '0;
      dir_p1  <= 1'b0;
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
    end else begin
      vld_p1  <= emit_p0;
      done_p1 <= pix_valid && rowEnd_p0 && lastRow_p0;
      if (emit_p0) begin
        col1_p1 <= lineMem[rowM4_p0][addr_p0];
        col2_p1 <= lineMem[rowM3_p0][addr_p0];
        col3_p1 <= lineMem[rowM2_p0][addr_p0];
        col4_p1 <= lineMem[rowM1_p0][addr_p0];
        col5_p1 <= pix_in;
        x_p1    <= x_p0;
        y_p1    <= y_p0 - 8'd2;
        dir_p1  <= dir_p0;
      end
    end
  end

  assign data1        = col1_p1;
  assign data2        = col2_p1;
  assign data3        = col3_p1;
  assign data4        = col4_p1;
  assign data5        = col5_p1;
  assign Xout         = x_p1;
  assign Yout         = y_p1;
  assign Directionout = dir_p1;
  assign col_valid    = vld_p1;
  assign frame_done   = done_p1;

endmodule

// File: doc/column_feeder.md
# column_feeder

Streaming 5-row line buffer that sits directly upstream of `DoGUnit`. It takes one pixel per accepted cycle in scan order, keeps the previous four image rows in on-chip line memories, and emits one vertical 5-pixel column per input pixel on `data1..data5`. Each column carries its coordinates and scan direction, so `DoGUnit` can shift it into its 5x5 window.

## Interface

Parameters:
- `IMG_W`, default 128: pixels per row, 5..256.
- `IMG_H`, default 128: rows per frame, 5..256.
- `SERPENTINE`, default 0: 0 = raster scan, every row left-to-right; 1 = odd rows arrive right-to-left.

Ports:
- `clk`  input  1: single clock; all logic on its rising edge.
- `rst`  input  1: asynchronous, active-low reset.
- `pix_in`  input  8: input pixel.
- `pix_valid`  input  1: `pix_in` is valid this cycle.
- `sof`  input  1: start of frame; sampled only when `pix_valid`=1.
- `data1`..`data5`  output  8 each: column, top row (y-4) to bottom row (y, the current row).
- `Xout`  output  8: column x coordinate.
- `Yout`  output  8: window centre row, y-2.
- `Directionout`  output  1: 0 = left-to-right row, 1 = right-to-left row.
- `col_valid`  output  1: column outputs are valid this cycle.
- `frame_done`  output  1: one-cycle pulse when the last pixel of a frame is accepted.

## Operation

- **Position counters.**
  - `x` range 0..IMG_W-1; `y` range 0..IMG_H-1; `dir` is a 1-bit row direction.
  - A pixel is accepted only when `pix_valid`=1; no state changes in any other cycle.
- **Position of each accepted pixel.**
  - With `sof`=1, the pixel is (0,0) with `dir`=0, whatever the counters hold.
  - Otherwise it takes the current counter position.
- **Counter advance after acceptance.**
  - `dir`=0: increment `x`.
  - `dir`=1: decrement `x`.
  - At the row end (x = IMG_W-1 when `dir`=0, or x = 0 when `dir`=1):
    - `y` increments.
    - If `SERPENTINE`=1, `dir` toggles and `x` stays at the edge.
    - If `SERPENTINE`=0, `x` returns to 0.
  - At the row end of y = IMG_H-1: `x`, `y` and `dir` return to 0, and `frame_done` pulses.
- **Line memories.**
  - Four arrays, each IMG_W x 8 bits, addressed by `x` (never by arrival order), so serpentine input needs no reordering.
  - A 2-bit rotating base index `rb` selects which array holds row y-1; the others hold y-2, y-3 and y-4 in rotation.
  - Each accepted pixel reads all four arrays at address `x`, then writes `pix_in` into the y-4 array at the same address.
  - Read-before-write in the same cycle: the read returns the old contents.
  - At each row end, `rb` advances by one, modulo 4.
  - `sof` resets `rb` to 0.
- **Column output.**
  - `data1` = row y-4, `data2` = y-3, `data3` = y-2, `data4` = y-1, `data5` = `pix_in`.
  - `Xout` = x, `Yout` = y-2, `Directionout` = `dir` of the accepted pixel.
- **col_valid.**
  - Asserted only for accepted pixels with y >= 4, i.e. rows 0..3 only fill the memories.
  - When `col_valid`=0, all data and coordinate outputs hold their last values.
- **Reset.**
  - Counters, `rb` and `dir` go to 0.
  - All outputs go to 0: `data1..5`=0, `Xout`=`Yout`=0, `Directionout`=0, `col_valid`=0, `frame_done`=0.
  - Memory contents are not cleared.
  - A reset in mid-frame drops the partial frame; the next accepted pixel is treated as (0,0) even if `sof`=0.

## Timing

- All outputs are registered. Latency is 1 cycle: a pixel accepted at edge N appears on the outputs, with `col_valid`, after edge N.
- Throughput is one pixel per cycle; there is no backpressure, because `DoGUnit` always accepts.
- `frame_done` asserts in the same output cycle as the column of the last pixel.
- `sof` together with the last pixel of a frame: `sof` wins; the pixel is (0,0) and there is no `frame_done` pulse.
- `pix_valid` gaps of any length are allowed anywhere, including across row and frame boundaries.

## Test plan

Benches use `IMG_W`=8, `IMG_H`=6, and pixel value = 16*y + x.

1. Raster frame, continuous `pix_valid`:
   - No `col_valid` for rows 0..3.
   - Pixel (3,4) produces `data1..5` = 0x03, 0x13, 0x23, 0x33, 0x43, with `Xout`=3, `Yout`=2, `Directionout`=0, one cycle later.
   - `frame_done` pulses once, with the column for (7,5).
2. Same frame with `pix_valid` toggled at random:
   - Output columns are identical to scenario 1, in the same order.
   - Outputs hold between valid cycles.
3. `SERPENTINE`=1:
   - Row 5 arrives x=7..0.
   - Its first column is 0x17, 0x27, 0x37, 0x47, 0x57 with `Xout`=7, `Yout`=3, `Directionout`=1.
4. Reset asserted mid-row 4, then a fresh frame without `sof`:
   - All outputs are 0 during reset.
   - The first `col_valid` occurs at the fifth new row, with correct data.
5. `sof` asserted at pixel (2,3) of a running frame:
   - Counting restarts at (0,0).
   - The next 4 rows produce no `col_valid`, and no `frame_done` appears for the aborted frame.
6. Two back-to-back frames with different pixel offsets:
   - The second frame's columns contain only second-frame data from y=4 onward.
